delay_line_mc: RTL and testbench

Multi-channel, time-multiplexed variable audio delay line with click-free delay slewing. Successor to the single-channel changeable delay: CHANNELS independent circular buffers share one memory, samples arrive as a valid-qualified TDM stream, and each channel's delay glides toward its target by a bounded step per sample instead of jumping or dropping data. It sits in the audio effect chain between the I2S/codec receive path and the effect mixers (echo, chorus, flanger).

---
 rtl/delay_line_mc_pkg.sv | 28 ++
 rtl/delay_mem_sdp.sv | 23 ++
 rtl/delay_line_mc.sv | 146 ++++++++++++++
 tb/tb_delay_line_mc.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/delay_line_mc_pkg.sv
// Shared audio types and width helpers for the multi-channel delay line.
package delay_line_mc_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 16;
  localparam int unsigned DELAY_WIDTH_DEF = 12;

  typedef logic [DATA_WIDTH_DEF-1:0] sample_t;

  // Where the registered output sample comes from.
  typedef enum logic {
    SRC_HOLD = 1'b0,
    SRC_MEM  = 1'b1
  } out_src_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned ch_width(input int unsigned channels);
    return (channels <= 1) ? 1 : clog2(channels);
  endfunction

endpackage

// File: rtl/delay_mem_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
module delay_mem_sdp #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/delay_line_mc.sv
// TDM multi-channel variable delay line with slewed per-channel delay.
module delay_line_mc
  import delay_line_mc_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter  int unsigned DELAY_WIDTH = DELAY_WIDTH_DEF,
  parameter  int unsigned CHANNELS    = 2,
  parameter  int unsigned SLEW_STEP   = 1,
  localparam int unsigned CH_W        = ch_width(CHANNELS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [CH_W-1:0]                 in_ch,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic [CHANNELS*DELAY_WIDTH-1:0] delay_target,
  output logic                            out_valid,
  output logic [CH_W-1:0]                 out_ch,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [CHANNELS*DELAY_WIDTH-1:0] delay_cur,
  output logic [CHANNELS-1:0]             settled
);

  localparam int unsigned AW    = CH_W + DELAY_WIDTH;
  localparam int unsigned DEPTH = CHANNELS << DELAY_WIDTH;

  typedef logic [DELAY_WIDTH-1:0] dly_t;

  dly_t                  wr_ptr [CHANNELS];
  dly_t                  fill   [CHANNELS];
  dly_t                  cur    [CHANNELS];
  dly_t                  tgt    [CHANNELS];
  logic [CHANNELS-1:0]   primed;

  logic                  sel_hit;
  logic                  sel_primed;
  dly_t                  sel_wr, sel_fill, sel_cur, sel_tgt, d_eff;
  logic                  accept_c;
  logic                  mem_re_c;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] out_hold;
  out_src_e              out_src;

  // Move cur toward tgt by at most SLEW_STEP.
  function automatic dly_t slew(input dly_t c, input dly_t t);
    dly_t diff;
    if (t > c) begin
      diff = t - c;
      return (32'(diff) > SLEW_STEP) ? c + DELAY_WIDTH'(SLEW_STEP) : t;
    end
    diff = c - t;
    return (32'(diff) > SLEW_STEP) ? c - DELAY_WIDTH'(SLEW_STEP) : t;
  endfunction

  // Unpack targets, publish current delays and settled flags.
  always_comb begin
    delay_cur = '0;
    settled   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      tgt[k] = delay_target[k*DELAY_WIDTH +: DELAY_WIDTH];
      delay_cur[k*DELAY_WIDTH +: DELAY_WIDTH] = cur[k];
      settled[k] = (cur[k] == tgt[k]);
    end
  end

  // Select the addressed channel's state; an unmatched in_ch is not accepted.
  always_comb begin
    sel_hit    = 1'b0;
    sel_primed = 1'b0;
    sel_wr     = '0;
    sel_fill   = '0;
    sel_cur    = '0;
    sel_tgt    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (in_ch == CH_W'(k)) begin
        sel_hit    = 1'b1;
        sel_primed = primed[k];
        sel_wr     = wr_ptr[k];
        sel_fill   = fill[k];
        sel_cur    = cur[k];
        sel_tgt    = tgt[k];
      end
    end
    accept_c = in_valid && sel_hit;
    // Before the first sample the target applies immediately.
    d_eff    = sel_primed ? sel_cur : sel_tgt;
    wr_addr  = {in_ch, sel_wr};
    rd_addr  = {in_ch, sel_wr - d_eff};
    mem_re_c = accept_c && (d_eff != '0) && (d_eff <= sel_fill);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      primed <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        wr_ptr[k] <= '0;
        fill[k]   <= '0;
        cur[k]    <= '0;
      end
    end else if (accept_c) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (in_ch == CH_W'(k)) begin
          wr_ptr[k] <= wr_ptr[k] + 1'b1;
          if (fill[k] != '1) fill[k] <= fill[k] + 1'b1;
          cur[k]    <= primed[k] ? slew(cur[k], tgt[k]) : tgt[k];
          primed[k] <= 1'b1;
        end
      end
    end
  end

  // Output stage: bypass/zero held in a register, delayed data from the RAM register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_hold  <= '0;
      out_src   <= SRC_HOLD;
    end else begin
      out_valid <= accept_c;
      if (accept_c) begin
        out_ch   <= in_ch;
        out_src  <= mem_re_c ? SRC_MEM : SRC_HOLD;
        out_hold <= (d_eff == '0) ? in_data : '0;
      end
    end
  end

  assign out_data = (out_src == SRC_MEM) ? rd_data : out_hold;

  delay_mem_sdp #(
    .WIDTH      (DATA_WIDTH),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (accept_c),
    .waddr (wr_addr),
    .wdata (in_data),
    .re    (mem_re_c),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_delay_line_mc.sv
// Randomized bench for delay_line_mc against a sample-history reference model.
module tb_delay_line_mc;

  localparam int unsigned DW  = 16;
  localparam int unsigned LW  = 4;
  localparam int unsigned CHA = 2;
  localparam int unsigned CHB = 3;
  localparam int unsigned HMAX = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [1:0]        in_ch = '0;
  logic [DW-1:0]     in_data = '0;
  logic              a_in_valid;
  logic [CHA*LW-1:0] a_target = '0;
  logic [CHB*LW-1:0] b_target = '0;

  logic              a_out_valid, b_out_valid;
  logic [0:0]        a_out_ch;
  logic [1:0]        b_out_ch;
  logic [DW-1:0]     a_out_data, b_out_data;
  logic [CHA*LW-1:0] a_delay_cur;
  logic [CHB*LW-1:0] b_delay_cur;
  logic [CHA-1:0]    a_settled;
  logic [CHB-1:0]    b_settled;

  assign a_in_valid = in_valid && (in_ch < 2'd2);

  delay_line_mc #(.DATA_WIDTH(DW), .DELAY_WIDTH(LW), .CHANNELS(CHA), .SLEW_STEP(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ch(in_ch[0]), .in_data(in_data),
    .delay_target(a_target), .out_valid(a_out_valid), .out_ch(a_out_ch),
    .out_data(a_out_data), .delay_cur(a_delay_cur), .settled(a_settled));

  delay_line_mc #(.DATA_WIDTH(DW), .DELAY_WIDTH(LW), .CHANNELS(CHB), .SLEW_STEP(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .delay_target(b_target), .out_valid(b_out_valid), .out_ch(b_out_ch),
    .out_data(b_out_data), .delay_cur(b_delay_cur), .settled(b_settled));

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state, index [instance][channel].
  int hist   [2][3][HMAX];
  int cnt    [2][3];
  int cur    [2][3];
  bit primed [2][3];
  int tgt    [2][3];
  int nch    [2] = '{2, 3};
  int slew_s [2] = '{1, 2};
  bit exp_valid [2];
  int exp_ch    [2];
  int exp_data  [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset(input int m);
    for (int k = 0; k < 3; k++) begin
      cnt[m][k] = 0; cur[m][k] = 0; primed[m][k] = 0;
    end
    exp_ch[m] = 0; exp_data[m] = 0;
  endfunction

  function automatic void model_accept(input int m, input int ch, input int x);
    int d, e, diff;
    d = primed[m][ch] ? cur[m][ch] : tgt[m][ch];
    if (d == 0) e = x;
    else if (d <= cnt[m][ch]) e = hist[m][ch][cnt[m][ch] - d];
    else e = 0;
    hist[m][ch][cnt[m][ch]] = x;
    cnt[m][ch]++;
    if (!primed[m][ch]) begin
      cur[m][ch] = tgt[m][ch];
      primed[m][ch] = 1;
    end else begin
      diff = tgt[m][ch] - cur[m][ch];
      if (diff > slew_s[m]) diff = slew_s[m];
      if (diff < -slew_s[m]) diff = -slew_s[m];
      cur[m][ch] = cur[m][ch] + diff;
    end
    exp_valid[m] = 1; exp_ch[m] = ch; exp_data[m] = e;
  endfunction

  task automatic compare_all(input bit r);
    check("a_valid", a_out_valid, exp_valid[0]);
    check("b_valid", b_out_valid, exp_valid[1]);
    if (exp_valid[0] || r) begin
      check("a_ch", a_out_ch, exp_ch[0]);
      check("a_data", a_out_data, exp_data[0]);
    end
    if (exp_valid[1] || r) begin
      check("b_ch", b_out_ch, exp_ch[1]);
      check("b_data", b_out_data, exp_data[1]);
    end
    for (int k = 0; k < CHA; k++) begin
      check($sformatf("a_cur%0d", k), a_delay_cur[k*LW +: LW], cur[0][k]);
      check($sformatf("a_settled%0d", k), a_settled[k], cur[0][k] == tgt[0][k]);
    end
    for (int k = 0; k < CHB; k++) begin
      check($sformatf("b_cur%0d", k), b_delay_cur[k*LW +: LW], cur[1][k]);
      check($sformatf("b_settled%0d", k), b_settled[k], cur[1][k] == tgt[1][k]);
    end
  endtask

  // One clock: drive at negedge, advance model, check just after the posedge.
  task automatic cycle(input bit r, input bit v, input int ch, input int x);
    int xm;
    xm = x & 32'hFFFF;
    @(negedge clk);
    rst = r; in_valid = v; in_ch = 2'(ch); in_data = DW'(xm);
    for (int k = 0; k < CHA; k++) a_target[k*LW +: LW] = LW'(tgt[0][k]);
    for (int k = 0; k < CHB; k++) b_target[k*LW +: LW] = LW'(tgt[1][k]);
    for (int m = 0; m < 2; m++) begin
      exp_valid[m] = 0;
      if (r) model_reset(m);
      else if (v && ch < nch[m]) model_accept(m, ch, xm);
    end
    @(posedge clk);
    #1;
    compare_all(r);
  endtask

  task automatic set_tgt(input int m, input int t0, input int t1, input int t2);
    tgt[m][0] = t0; tgt[m][1] = t1; tgt[m][2] = t2;
  endtask

  initial begin
    int p1_exp [5];
    int ch, force_rst;
    p1_exp = '{0, 0, 0, 1, 2};
    for (int m = 0; m < 2; m++) begin
      model_reset(m);
      set_tgt(m, 0, 0, 0);
    end

    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);

    // Delay 3 on ch0, bypass on ch1.
    set_tgt(0, 3, 0, 0); set_tgt(1, 3, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 1, 0, i);
      check("p1_ch0_out", a_out_data, p1_exp[i-1]);
    end
    cycle(0, 1, 1, 7);
    check("p1_bypass", a_out_data, 7);

    // Interleaved channels, delays 4 and 8.
    cycle(1, 0, 0, 0);
    set_tgt(0, 4, 8, 0); set_tgt(1, 4, 8, 5);
    for (int n = 0; n < 24; n++) begin
      cycle(0, 1, 0, 100 + n);
      cycle(0, 1, 1, 200 + n);
      if (n >= 8) check("p2_ch1_out", a_out_data, 200 + n - 8);
    end

    // Slewing: a 10 -> 14 step 1, b 14 -> 10 step 2.
    cycle(1, 0, 0, 0);
    set_tgt(0, 10, 0, 0); set_tgt(1, 14, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 500 + i);
    set_tgt(0, 14, 0, 0); set_tgt(1, 10, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 600 + i);
      check("slew_a_cur", a_delay_cur[LW-1:0], 11 + i);
      check("slew_a_settled", a_settled[0], i == 3);
      check("slew_b_cur", b_delay_cur[LW-1:0], (i == 0) ? 12 : 10);
    end

    // Maximum delay across pointer wrap.
    cycle(1, 0, 0, 0);
    set_tgt(0, 15, 15, 0); set_tgt(1, 15, 15, 15);
    for (int i = 0; i < 40; i++) cycle(0, 1, 0, 1000 + i);
    check("wrap_out", a_out_data, 1000 + 39 - 15);

    // Invalid channel leaves everything unchanged.
    cycle(0, 1, 3, 999);
    check("inv_b_valid", b_out_valid, 0);
    cycle(0, 1, 0, 2000);
    check("inv_after", b_out_data, 1000 + 40 - 15);

    // Randomized traffic with mid-stream resets and target changes.
    for (int i = 0; i < 3000; i++) begin
      force_rst = 0;
      for (int m = 0; m < 2; m++)
        for (int k = 0; k < 3; k++)
          if (cnt[m][k] >= 1000) force_rst = 1;
      if ($urandom_range(0, 15) == 0) begin
        ch = $urandom_range(0, 2);
        tgt[$urandom_range(0, 1)][ch] = $urandom_range(0, 15);
      end
      cycle(($urandom_range(0, 199) == 0) || (force_rst != 0),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
